// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer: selection modes and output-stage states.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
    parameter int NUM_CH = 32,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    int cand;

    // Offset NUM_CH revisits ptr itself, so the previous winner is served last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = (int'(ptr) + off) % NUM_CH;
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt_idx   = IDX_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with explicit-select or round-robin arbitration and a
// one-deep registered output stage that sustains one word per cycle.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int DATA_W = 2,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready,
    output logic                     err_sel
);

    stage_state_t      state;
    logic [SEL_W-1:0]  ptr;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic              sel_ok;
    logic [NUM_CH-1:0] sel_gnt;
    logic [NUM_CH-1:0] rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_any;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              load;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = in_data[i*DATA_W +: DATA_W];
        end
    end

    assign sel_ok = (int'(sel) < NUM_CH);

    always_comb begin
        sel_gnt = '0;
        if (sel_ok && in_valid[sel]) begin
            sel_gnt[sel] = 1'b1;
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (SEL_W)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end else begin
            gnt     = sel_gnt;
            gnt_idx = sel;
            gnt_any = |sel_gnt;
        end
    end

    // The stage can accept when empty or when its held word leaves this cycle.
    assign load      = (state == ST_EMPTY) || out_ready;
    assign in_ready  = (rst_n && load) ? gnt : '0;
    assign out_valid = (state == ST_FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            err_sel  <= 1'b0;
            ptr      <= SEL_W'(NUM_CH - 1);
        end else begin
            err_sel <= (mode == MODE_SEL) && !sel_ok;
            if (load) begin
                if (gnt_any) begin
                    state    <= ST_FULL;
                    out_data <= ch_data[gnt_idx];
                    out_ch   <= gnt_idx;
                    if (mode == MODE_RR) begin
                        ptr <= gnt_idx;
                    end
                end else begin
                    state <= ST_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: a vector table plus corner-case sequences, with a
// reference-model scoreboard tracking every transfer on the 32-channel instance.
module tb_stream_mux_arb;
    import stream_mux_pkg::*;

    localparam int N  = 32;
    localparam int N2 = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = MODE_SEL;
    logic [4:0]    sel = 5'd5;
    logic [N-1:0]  in_valid = '1;
    logic [2*N-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [1:0]    out_data;
    logic [4:0]    out_ch;
    logic          out_ready = 1'b1;
    logic          err_sel;

    logic          mode24 = MODE_SEL;
    logic [4:0]    sel24 = 5'd4;
    logic [N2-1:0] in_valid24 = '1;
    logic [2*N2-1:0] in_data24;
    logic [N2-1:0] in_ready24;
    logic          out_valid24;
    logic [1:0]    out_data24;
    logic [4:0]    out_ch24;
    logic          out_ready24 = 1'b1;
    logic          err_sel24;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ch;
        int data;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    typedef struct {
        logic         mode;
        logic [4:0]   sel;
        logic [N-1:0] valid;
        logic         rdy;
        logic [N-1:0] exp_ready;
        logic         exp_ovalid;
        int           exp_ch;
        int           exp_data;
    } vec_t;
    vec_t vecs[12];

    logic         m_full = 1'b0;
    int           m_ptr  = N - 1;
    logic         m_err  = 1'b0;

    stream_mux_arb #(.NUM_CH(N), .DATA_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .err_sel   (err_sel)
    );

    stream_mux_arb #(.NUM_CH(N2), .DATA_W(2)) dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode24),
        .sel       (sel24),
        .in_valid  (in_valid24),
        .in_data   (in_data24),
        .in_ready  (in_ready24),
        .out_valid (out_valid24),
        .out_data  (out_data24),
        .out_ch    (out_ch24),
        .out_ready (out_ready24),
        .err_sel   (err_sel24)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [4:0] s, input logic [N-1:0] v,
                                 input logic r);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int modelGrant(input logic m, input int s, input logic [N-1:0] v,
                                      input int p);
        int c;
        if (m == MODE_SEL) begin
            return (s < N && v[s]) ? s : -1;
        end
        for (int k = 1; k <= N; k++) begin
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference model and scoreboard: sampled mid-cycle, predicting the next rising edge.
    always @(negedge clk) begin
        int        g;
        logic      ld;
        sb_entry_t e;
        logic [N-1:0] exp_rdy;
        checkOutput("sb_out_valid", 64'(out_valid), 64'(m_full));
        checkOutput("sb_err_sel", 64'(err_sel), 64'(m_err));
        if (!rst_n) begin
            checkOutput("sb_in_ready_reset", 64'(in_ready), 64'd0);
            sb_q.delete();
            m_full = 1'b0;
            m_ptr  = N - 1;
            m_err  = 1'b0;
        end else begin
            g  = modelGrant(mode, int'(sel), in_valid, m_ptr);
            ld = !m_full || out_ready;
            exp_rdy = '0;
            if (ld && g >= 0) exp_rdy[g] = 1'b1;
            checkOutput("sb_in_ready", 64'(in_ready), 64'(exp_rdy));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_unexpected_word", 64'(out_ch), 64'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_out_ch", 64'(out_ch), 64'(e.ch));
                    checkOutput("sb_out_data", 64'(out_data), 64'(e.data));
                end
            end
            m_err = (mode == MODE_SEL) && (int'(sel) >= N);
            if (ld) begin
                if (g >= 0) begin
                    e.ch   = g;
                    e.data = g & 3;
                    sb_q.push_back(e);
                    m_full = 1'b1;
                    if (mode == MODE_RR) m_ptr = g;
                end else begin
                    m_full = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] rr_pair;
        logic [N-1:0] bp_pair;
        logic [N-1:0] rst_pair;

        for (int i = 0; i < N; i++) in_data[i*2 +: 2] = 2'(i & 3);
        for (int i = 0; i < N2; i++) in_data24[i*2 +: 2] = 2'(i & 3);

        rr_pair  = '0; rr_pair[3]  = 1'b1; rr_pair[30] = 1'b1;
        bp_pair  = '0; bp_pair[2]  = 1'b1; bp_pair[9]  = 1'b1;
        rst_pair = '0; rst_pair[6] = 1'b1; rst_pair[20] = 1'b1;

        vecs[0]  = '{MODE_SEL, 5'd5,  '1,      1'b1, 32'h1 << 5,  1'b0, 0,  0};
        vecs[1]  = '{MODE_SEL, 5'd5,  '1,      1'b1, 32'h1 << 5,  1'b1, 5,  1};
        vecs[2]  = '{MODE_SEL, 5'd31, '0,      1'b1, 32'h0,       1'b1, 5,  1};
        vecs[3]  = '{MODE_SEL, 5'd2,  32'h4,   1'b1, 32'h1 << 2,  1'b0, 0,  0};
        vecs[4]  = '{MODE_RR,  5'd0,  '1,      1'b1, 32'h1,       1'b1, 2,  2};
        vecs[5]  = '{MODE_RR,  5'd0,  '1,      1'b1, 32'h2,       1'b1, 0,  0};
        vecs[6]  = '{MODE_RR,  5'd0,  rr_pair, 1'b1, 32'h1 << 3,  1'b1, 1,  1};
        vecs[7]  = '{MODE_RR,  5'd0,  rr_pair, 1'b1, 32'h1 << 30, 1'b1, 3,  3};
        vecs[8]  = '{MODE_RR,  5'd0,  rr_pair, 1'b1, 32'h1 << 3,  1'b1, 30, 2};
        vecs[9]  = '{MODE_RR,  5'd0,  '1,      1'b0, 32'h0,       1'b1, 3,  3};
        vecs[10] = '{MODE_RR,  5'd0,  '1,      1'b1, 32'h1 << 4,  1'b1, 3,  3};
        vecs[11] = '{MODE_SEL, 5'd9,  '1,      1'b1, 32'h1 << 9,  1'b1, 4,  0};

        // Reset values, with valid inputs present to show in_ready stays low.
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_ch", 64'(out_ch), 64'd0);
        checkOutput("reset_err_sel", 64'(err_sel), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        nextCycle();
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            applyStimulus(vecs[k].mode, vecs[k].sel, vecs[k].valid, vecs[k].rdy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].exp_ready));
            checkOutput($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].exp_ovalid));
            if (vecs[k].exp_ovalid) begin
                checkOutput($sformatf("vec%0d_out_ch", k), 64'(out_ch), 64'(vecs[k].exp_ch));
                checkOutput($sformatf("vec%0d_out_data", k), 64'(out_data), 64'(vecs[k].exp_data));
            end
            nextCycle();
        end

        // Round-robin over all channels: 34 words, no bubbles, wrapping 31 -> 0.
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(MODE_RR, 5'd0, '1, 1'b1);
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput("rr_first_in_ready", 64'(in_ready), 64'd1);
            end else begin
                checkOutput($sformatf("rr_seq%0d_valid", k), 64'(out_valid), 64'd1);
                checkOutput($sformatf("rr_seq%0d_ch", k), 64'(out_ch), 64'((k - 1) % N));
            end
            nextCycle();
        end

        // Backpressure on a held channel 7; ptr must still point at 31 afterwards.
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(MODE_SEL, 5'd7, '1, 1'b1);
        nextCycle();
        applyStimulus(MODE_RR, 5'd0, '1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
            checkOutput($sformatf("bp%0d_out_ch", k), 64'(out_ch), 64'd7);
            checkOutput($sformatf("bp%0d_out_data", k), 64'(out_data), 64'd3);
            checkOutput($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
            nextCycle();
        end
        applyStimulus(MODE_RR, 5'd0, bp_pair, 1'b1);
        @(negedge clk);
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'(32'h1 << 2));
        nextCycle();

        // Reset while holding channel 2 discards the word; first RR grant is lowest valid.
        rst_n = 1'b0;
        applyStimulus(MODE_RR, 5'd0, rst_pair, 1'b1);
        @(negedge clk);
        checkOutput("midrst_held_ch", 64'(out_ch), 64'd2);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_ch", 64'(out_ch), 64'd0);
        checkOutput("midrst_first_grant", 64'(in_ready), 64'(32'h1 << 6));
        nextCycle();
        @(negedge clk);
        checkOutput("midrst_word_ch", 64'(out_ch), 64'd6);
        checkOutput("midrst_word_data", 64'(out_data), 64'd2);

        // 24-channel instance: out-of-range select raises err_sel for one cycle.
        nextCycle();
        sel24 = 5'd28;
        @(negedge clk);
        checkOutput("ch24_oor_in_ready", 64'(in_ready24), 64'd0);
        checkOutput("ch24_oor_err_before", 64'(err_sel24), 64'd0);
        nextCycle();
        sel24 = 5'd4;
        @(negedge clk);
        checkOutput("ch24_err_set", 64'(err_sel24), 64'd1);
        checkOutput("ch24_no_grant_empty", 64'(out_valid24), 64'd0);
        checkOutput("ch24_restored_in_ready", 64'(in_ready24), 64'(24'h1 << 4));
        nextCycle();
        @(negedge clk);
        checkOutput("ch24_err_clear", 64'(err_sel24), 64'd0);
        checkOutput("ch24_out_valid", 64'(out_valid24), 64'd1);
        checkOutput("ch24_out_ch", 64'(out_ch24), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
